// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: start-bit filtering, 2-of-3 majority
// sampling, 5..MAX_DATA_BITS data bits, optional parity, 1/2 stop bits, ready/valid output.
module uart_rx_param #(
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned MAX_DATA_BITS = 9
) (
    input  logic                     clk_16bd,
    input  logic                     rst,
    input  logic                     Rx,
    input  logic                     parity,
    input  logic                     parity_type,
    input  logic                     stop_bits,
    input  logic [3:0]               frame_length,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     break_det,
    output logic                     overrun
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_MLO  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_MHI  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LEN_MIN = 4'd5;
    localparam logic [3:0]    LEN_MAX = 4'(MAX_DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic                     rx_meta, rxs, rxs_d;
    logic [2:0]               state, state_nxt;
    logic [CW-1:0]            cnt;
    logic                     smp0, smp1;
    logic [3:0]               bit_idx;
    logic                     stop_idx;
    logic [3:0]               len_q;
    logic                     par_q, ptype_q, two_q;
    logic [MAX_DATA_BITS-1:0] data_q;
    logic                     pe_q, pbit_q;

    logic                     wrap_c, decide_c, maj_c, start_c;
    logic                     done_c, fe_c, be_c;
    logic [3:0]               len_c;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        wrap_c   = (cnt == C_LAST);
        decide_c = (cnt == C_MHI);
        maj_c    = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
        start_c  = (state == S_IDLE) && rxs_d && !rxs;
        if (frame_length < LEN_MIN)      len_c = LEN_MIN;
        else if (frame_length > LEN_MAX) len_c = LEN_MAX;
        else                             len_c = frame_length;
    end

    always_comb begin
        state_nxt = state;
        done_c    = 1'b0;
        fe_c      = 1'b0;
        be_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_c) state_nxt = S_START;
            end
            S_START: begin
                if (decide_c && maj_c) state_nxt = S_IDLE;
                else if (wrap_c)       state_nxt = S_DATA;
            end
            S_DATA: begin
                if (wrap_c && (bit_idx == len_q - 4'd1))
                    state_nxt = par_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (wrap_c) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Completion is taken at the decision point so the next start edge is seen mid-bit
                if (decide_c) begin
                    if (!maj_c) begin
                        done_c    = 1'b1;
                        fe_c      = 1'b1;
                        be_c      = (data_q == '0) && (!par_q || !pbit_q);
                        state_nxt = S_WAIT;
                    end else if (!(two_q && !stop_idx)) begin
                        done_c    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (rxs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timing, sampling and frame assembly
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            len_q    <= LEN_MIN;
            par_q    <= 1'b0;
            ptype_q  <= 1'b0;
            two_q    <= 1'b0;
            data_q   <= '0;
            pe_q     <= 1'b0;
            pbit_q   <= 1'b0;
        end else begin
            if (state == S_IDLE)                                cnt <= start_c ? CW'(1) : '0;
            else if (state_nxt == S_IDLE || state_nxt == S_WAIT) cnt <= '0;
            else if (wrap_c)                                     cnt <= '0;
            else                                                 cnt <= cnt + CW'(1);

            if (cnt == C_MLO) smp0 <= rxs;
            if (cnt == C_MID) smp1 <= rxs;

            if (start_c) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                len_q    <= len_c;
                par_q    <= parity;
                ptype_q  <= parity_type;
                two_q    <= stop_bits;
                data_q   <= '0;
                pe_q     <= 1'b0;
                pbit_q   <= 1'b0;
            end

            if (state == S_DATA && decide_c) begin
                for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
                    if (bit_idx == 4'(i)) data_q[i] <= maj_c;
                end
            end
            if (state == S_DATA && wrap_c) bit_idx <= bit_idx + 4'd1;

            if (state == S_PARITY && decide_c) begin
                pbit_q <= maj_c;
                pe_q   <= ((^data_q) ^ maj_c) != ptype_q;
            end

            if (state == S_STOP && wrap_c) stop_idx <= 1'b1;
        end
    end

    // Ready/valid holding register with overrun tracking
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done_c) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= data_q;
                parity_err <= par_q & pe_q;
                frame_err  <= fe_c;
                break_det  <= be_c;
                overrun    <= 1'b0;
                rx_valid   <= 1'b1;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: generalised successor of the single-frame receiver in the VGA command path. Runs on the oversampled baud clock, filters the start bit, majority-votes each bit and supports 5..MAX_DATA_BITS data bits, optional even/odd parity and 1/2 stop bits. It reports parity, framing, break and overrun status and holds each completed frame in a ready/valid output register. Sits between the Rx pin and the command decoder.

## Interface
- OVERSAMPLE, 16: clk_16bd cycles per bit; even, ≥8.
- MAX_DATA_BITS, 9: width of rx_data; maximum frame_length.
- clk_16bd  in  1  oversampled baud clock, OVERSAMPLE ticks per bit.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- Rx  in  1  serial line, asynchronous, idle high.
- parity  in  1  1 = parity bit present.
- parity_type  in  1  0 = even, 1 = odd.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- frame_length  in  4  data bits per frame; clamped to 5..MAX_DATA_BITS.
- rx_data  out  MAX_DATA_BITS  received word, LSB = first bit; unused high bits 0.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the word on rx_valid && rx_ready.
- parity_err, frame_err, break_det, overrun  out  1 each  status of the held word.

## Operation
- Rx passes through a 2-flop synchroniser (reset value 1) to give rxs; rxs_d is rxs delayed one cycle.
- Configuration inputs are latched on start detection; changes mid-frame have no effect.
- Bit counter cnt runs 0..OVERSAMPLE-1 and wraps. Samples are taken at M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the 2-of-3 majority and is decided at cnt = M+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rxs_d = 1 and rxs = 0, go to START with cnt = 1.
- START: if the majority is 1, this is a false start: return to IDLE with no output. Otherwise go to DATA at cnt wrap.
- DATA: bit i is stored into data[i]. After frame_length bits, go to PARITY if parity = 1, else STOP, at cnt wrap.
- PARITY: pe = 1 when XOR(data, parity bit) ≠ parity_type.
- STOP: each stop bit is decided at M+1.
  - Stop bit 1 with stop_bits = 1: wait to cnt wrap, then check the second stop bit.
  - Last stop bit 1: the frame completes and the FSM goes to IDLE at the decision cycle. This is mid-bit resync.
  - Any stop bit 0: the frame completes with fe = 1 and the FSM goes to WAIT_IDLE.
  - Break: all data bits 0, the parity bit (if present) 0, and the stop bit 0. This sets be = 1 along with fe = 1.
- WAIT_IDLE: stay until rxs = 1, then go to IDLE.
- Completion when rx_valid = 0, or when rx_valid && rx_ready in the same cycle: load rx_data, parity_err, frame_err and break_det; clear overrun; set rx_valid.
- Completion when rx_valid = 1 and rx_ready = 0: the new frame is discarded, overrun is set to 1, and the held word is unchanged.
- Handshake with no completion: rx_valid and overrun clear; data and status bits keep their values.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, break_det = 0, overrun = 0. FSM = IDLE, cnt = 0, synchroniser = 1.
- Reset asserted mid-frame: everything returns to reset values immediately; the partial frame is lost.
- Start latency: a falling edge on Rx is detected 3 clk_16bd cycles later (2 for the synchroniser, 1 for edge detection).
- Output latency: rx_valid rises 1 cycle after the decision at M+1 of the last stop bit. For 8N1 at OVERSAMPLE 16 this is 9*16 + 9 + 1 cycles after detection.
- rx_valid stays high until the handshake. Data and status bits are stable while rx_valid = 1.
- A glitch shorter than 2 sample points within M-1..M+1 is rejected. The minimum accepted start is 2 of 3 low samples.

## Test plan
- 8N1, frame_length 8, word 0xA5 at 16 clk_16bd per bit: rx_data = 0x0A5, rx_valid after 154 cycles, all status bits 0; a handshake clears rx_valid.
- 7E2, frame_length 7, word 0x41 sent with the parity bit set to 1: parity_err = 1, frame_err = 0. Same frame with the correct parity bit 0: parity_err = 0.
- Rx low for 4 cycles starting in IDLE: no rx_valid, FSM back in IDLE. A following valid 0x3C frame is received correctly.
- 8N1 frame 0x55 with stop bit 0: frame_err = 1, break_det = 0. With Rx held low for 2 frames then released: break_det = 1 and frame_err = 1, only one completion, next frame accepted only after Rx returns high.
- Two back-to-back frames 0x11 and 0x22 with rx_ready = 0: rx_data = 0x011, overrun = 1. A handshake at the exact completion cycle of a third frame 0x33 loads 0x033 with overrun = 0.
- rst asserted mid-DATA of frame 0xFF, then released: all outputs 0. The next frame 0x81 is received intact.
